// File: rtl/axi_lite_dmem_slave_if.sv
// AXI4-Lite bus bundle between the pipeline's data-memory master and the
// axi_lite_dmem_slave RAM target. Clock and reset travel as plain ports.
interface axi_lite_dmem_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  // Write address channel
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic [2:0]            s_awprot;
  logic                  s_awvalid;
  logic                  s_awready;
  // Write data channel
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  // Write response channel
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;
  // Read address channel
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [2:0]            s_arprot;
  logic                  s_arvalid;
  logic                  s_arready;
  // Read data channel
  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;

  modport master (
    output s_awaddr, s_awprot, s_awvalid, input  s_awready,
    output s_wdata,  s_wstrb,  s_wvalid,  input  s_wready,
    input  s_bresp,  s_bvalid, output s_bready,
    output s_araddr, s_arprot, s_arvalid, input  s_arready,
    input  s_rdata,  s_rresp,  s_rvalid,  output s_rready
  );

  modport slave (
    input  s_awaddr, s_awprot, s_awvalid, output s_awready,
    input  s_wdata,  s_wstrb,  s_wvalid,  output s_wready,
    output s_bresp,  s_bvalid, input  s_bready,
    input  s_araddr, s_arprot, s_arvalid, output s_arready,
    output s_rdata,  s_rresp,  s_rvalid,  input  s_rready
  );
endinterface

// File: rtl/axi_lite_dmem_slave.sv
// AXI4-Lite slave data memory: word-organised RAM with byte-lane strobes,
// independent read/write channels and RD_WAIT read wait states.
// Addresses outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4) answer SLVERR.
// Optional build macro DMEM_ALIGN_CHECK_EN: when defined, any address with
// addr[1:0] != 0 answers SLVERR, its write is dropped and its read data is 0.
module axi_lite_dmem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    RD_WAIT     = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  axi_lite_dmem_slave_if.slave  s
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH_WORDS * 4);
  localparam logic [3:0] CNT_INIT = 4'(RD_WAIT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [0:0] {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} rstate_t;

  // Write side state
  wstate_t               r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_aw_full;
  logic                  r_w_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [31:0]           r_w_data;
  logic [3:0]            r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  // Read side state
  rstate_t               r_rstate;
  logic                  r_arready;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [3:0]            r_cnt;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic                  r_rd_ok;

  // Address decode for the held write address and the latched read address
  logic [ADDR_WIDTH-1:0] w_aw_off;
  logic [ADDR_WIDTH-1:0] w_ar_off;
  logic [IDX_W-1:0]      w_aw_idx;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_aw_ok;
  logic                  w_ar_ok;
  logic                  w_commit;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [31:0]           w_ram_q;
  logic                  w_unused;

  assign w_aw_off = r_aw_addr - BASE_ADDR;
  assign w_ar_off = r_ar_addr - BASE_ADDR;
  assign w_aw_idx = w_aw_off[IDX_W+1:2];
  assign w_ar_idx = w_ar_off[IDX_W+1:2];
  assign w_aw_ok  = (w_aw_off < SPAN) && (!ALIGN_CHK || (r_aw_addr[1:0] == 2'b00));
  assign w_ar_ok  = (w_ar_off < SPAN) && (!ALIGN_CHK || (r_ar_addr[1:0] == 2'b00));

  // Commit happens on the edge where both holders are full; bad addresses
  // still commit (to produce SLVERR) but never touch the RAM.
  assign w_commit = (r_wstate == W_COLLECT) && r_aw_full && r_w_full;
  assign w_wr_en  = w_commit && w_aw_ok;
  assign w_rd_en  = (r_rstate == R_WAIT) && (r_cnt == 4'd0) && w_ar_ok;

  // Protection bits carry no meaning for this memory.
  assign w_unused = ^{s.s_awprot, s.s_arprot};

  assign s.s_awready = r_awready;
  assign s.s_wready  = r_wready;
  assign s.s_bvalid  = r_bvalid;
  assign s.s_bresp   = r_bresp;
  assign s.s_arready = r_arready;
  assign s.s_rvalid  = r_rvalid;
  assign s.s_rresp   = r_rresp;
  // Read data is forced to 0 outside a valid in-range beat; the RAM output
  // register only changes while sampling, so it is stable across R stalls.
  assign s.s_rdata   = r_rd_ok ? w_ram_q : 32'd0;

  // One byte-wide RAM per lane so each strobe maps onto a lane write enable.
  // Read and write on the same edge return the old contents.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_lane_q;

      // Lane write on commit with strobe, registered read on sample
      always_ff @(posedge clk) begin
        if (w_wr_en && r_w_strb[gi]) begin
          r_mem[w_aw_idx] <= r_w_data[8*gi +: 8];
        end
        if (w_rd_en) begin
          r_lane_q <= r_mem[w_ar_idx];
        end
      end

      assign w_ram_q[8*gi +: 8] = r_lane_q;
    end
  endgenerate

  // Write FSM: collect AW and W in any order, commit, then hold B until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_COLLECT;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= 32'd0;
      r_w_strb  <= 4'd0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_COLLECT: begin
          if (r_aw_full && r_w_full) begin
            r_bresp   <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
            r_bvalid  <= 1'b1;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wstate  <= W_RESP;
          end else begin
            if (s.s_awvalid && r_awready) begin
              r_aw_addr <= s.s_awaddr;
              r_aw_full <= 1'b1;
              r_awready <= 1'b0;
            end else begin
              r_awready <= !r_aw_full;
            end
            if (s.s_wvalid && r_wready) begin
              r_w_data <= s.s_wdata;
              r_w_strb <= s.s_wstrb;
              r_w_full <= 1'b1;
              r_wready <= 1'b0;
            end else begin
              r_wready <= !r_w_full;
            end
          end
        end
        W_RESP: begin
          if (s.s_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_COLLECT;
          end
        end
        default: begin
          r_wstate <= W_COLLECT;
        end
      endcase
    end
  end

  // Read FSM: latch AR, count wait states, present R until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_ar_addr <= '0;
      r_cnt     <= 4'd0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rd_ok   <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (s.s_arvalid && r_arready) begin
            r_ar_addr <= s.s_araddr;
            r_cnt     <= CNT_INIT;
            r_arready <= 1'b0;
            r_rstate  <= R_WAIT;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
            r_rd_ok  <= w_ar_ok;
            r_rstate <= R_VALID;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_VALID: begin
          if (s.s_rready) begin
            r_rvalid  <= 1'b0;
            r_rd_ok   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: begin
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_dmem_slave.sv
// Scoreboard bench for axi_lite_dmem_slave: drivers push expected B/R
// responses from a word-array reference model; a negedge monitor pops and
// compares on every handshake and checks stability under backpressure.
module tb_axi_lite_dmem_slave;
  localparam int          AW    = 32;
  localparam int          DEPTH = 1024;
  localparam int          RDW   = 3;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_dmem_slave_if #(.ADDR_WIDTH(AW)) bus ();

  axi_lite_dmem_slave #(
    .ADDR_WIDTH (AW),
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .RD_WAIT    (RDW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0]  exp_b [$];
  rexp_t       exp_r [$];
  logic [31:0] model [0:15];   // reference contents of words 0..15

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  // Reference decode: byte offset from base, window check, optional alignment
  function automatic void decode(input logic [31:0] a, output bit err, output int idx);
    logic [31:0] off;
    off = a - BASE;
    err = !(off < 32'(DEPTH * 4));
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) err = 1'b1;
`endif
    idx = int'(off[11:2]);
  endfunction

  // ---------------- monitor ----------------
  bit          r_pend, b_pend;
  logic [31:0] r_hold_d;
  logic [1:0]  r_hold_r, b_hold;
  rexp_t       r_e;
  logic [1:0]  b_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      r_pend = 1'b0;
      b_pend = 1'b0;
    end else begin
      if (bus.s_rvalid) begin
        check("arready_low_while_rvalid", 32'(bus.s_arready), 32'd0);
        if (r_pend) begin
          check("rdata_stable", bus.s_rdata, r_hold_d);
          check("rresp_stable", 32'(bus.s_rresp), 32'(r_hold_r));
        end
        if (exp_r.size() == 0) begin
          fail_now("r_unexpected");
          r_pend = 1'b0;
        end else if (bus.s_rready) begin
          r_e = exp_r.pop_front();
          check("rdata", bus.s_rdata, r_e.data);
          check("rresp", 32'(bus.s_rresp), 32'(r_e.resp));
          r_pend = 1'b0;
        end else begin
          r_pend   = 1'b1;
          r_hold_d = bus.s_rdata;
          r_hold_r = bus.s_rresp;
        end
      end else if (r_pend) begin
        fail_now("r_dropped_before_ready");
        r_pend = 1'b0;
      end

      if (bus.s_bvalid) begin
        check("awready_low_while_bvalid", 32'(bus.s_awready), 32'd0);
        check("wready_low_while_bvalid", 32'(bus.s_wready), 32'd0);
        if (b_pend) check("bresp_stable", 32'(bus.s_bresp), 32'(b_hold));
        if (exp_b.size() == 0) begin
          fail_now("b_unexpected");
          b_pend = 1'b0;
        end else if (bus.s_bready) begin
          b_e = exp_b.pop_front();
          check("bresp", 32'(bus.s_bresp), 32'(b_e));
          b_pend = 1'b0;
        end else begin
          b_pend = 1'b1;
          b_hold = bus.s_bresp;
        end
      end else if (b_pend) begin
        fail_now("b_dropped_before_ready");
        b_pend = 1'b0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_aw(input logic [31:0] a, input int dly, output bit ok);
    ok = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    bus.s_awaddr  = a;
    bus.s_awprot  = 3'($urandom);
    bus.s_awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    if (!ok) fail_now("aw_handshake_timeout");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input int dly, output bit ok);
    ok = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    bus.s_wdata  = d;
    bus.s_wstrb  = strb;
    bus.s_wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0;
    if (!ok) fail_now("w_handshake_timeout");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int bstall);
    bit err, ok1, ok2, got;
    int idx;
    fork
      send_aw(a, aw_dly, ok1);
      send_w(d, strb, w_dly, ok2);
    join
    if (!(ok1 && ok2)) return;
    decode(a, err, idx);
    exp_b.push_back(err ? 2'b10 : 2'b00);
    if (!err) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) model[idx][8*i +: 8] = d[8*i +: 8];
    end
    $display("WR addr=%h data=%h strb=%b exp_resp=%b", a, d, strb, err ? 2'b10 : 2'b00);
    check("bvalid_not_early", 32'(bus.s_bvalid), 32'd0);
    @(posedge clk); #1;
    check("b_latency_one", 32'(bus.s_bvalid), 32'd1);
    repeat (bstall) begin @(posedge clk); #1; end
    bus.s_bready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_bvalid && bus.s_bready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.s_bready = 1'b0;
    if (!got) begin fail_now("b_handshake_timeout"); return; end
    check("awready_after_b", 32'(bus.s_awready), 32'd1);
    check("wready_after_b", 32'(bus.s_wready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input int rstall, input bit complete);
    bit err, ok, got;
    int idx, lat;
    rexp_t e;
    decode(a, err, idx);
    e.data = err ? 32'd0 : model[idx];
    e.resp = err ? 2'b10 : 2'b00;
    exp_r.push_back(e);
    $display("RD addr=%h exp_data=%h exp_resp=%b", a, e.data, e.resp);
    bus.s_araddr  = a;
    bus.s_arprot  = 3'($urandom);
    bus.s_arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    if (!ok) begin fail_now("ar_handshake_timeout"); return; end
    lat = 0;
    while (!bus.s_rvalid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("r_latency", 32'(lat), 32'(RDW));
    if (!complete) return;
    repeat (rstall) begin @(posedge clk); #1; end
    bus.s_rready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_rvalid && bus.s_rready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.s_rready = 1'b0;
    if (!got) fail_now("r_handshake_timeout");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(bus.s_awready), 32'd0);
    check({tag, "_wready"},  32'(bus.s_wready),  32'd0);
    check({tag, "_arready"}, 32'(bus.s_arready), 32'd0);
    check({tag, "_bvalid"},  32'(bus.s_bvalid),  32'd0);
    check({tag, "_rvalid"},  32'(bus.s_rvalid),  32'd0);
    check({tag, "_bresp"},   32'(bus.s_bresp),   32'd0);
    check({tag, "_rresp"},   32'(bus.s_rresp),   32'd0);
    check({tag, "_rdata"},   bus.s_rdata,        32'd0);
  endtask

  task automatic check_readies_up(input string tag);
    check({tag, "_awready"}, 32'(bus.s_awready), 32'd1);
    check({tag, "_wready"},  32'(bus.s_wready),  32'd1);
    check({tag, "_arready"}, 32'(bus.s_arready), 32'd1);
  endtask

  // Global bound so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] oor [4];

  initial begin
    oor[0] = 32'h0000_1000;
    oor[1] = 32'h0000_1004;
    oor[2] = 32'h2000_0010;
    oor[3] = 32'hFFFF_FFFC;
    bus.s_awaddr = '0; bus.s_awprot = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata = '0;  bus.s_wstrb = '0;  bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    bus.s_araddr = '0; bus.s_arprot = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;

    // Reset state, then readies rise one cycle after release
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_readies_up("post_reset");

    // Fill the modelled window so every later read has known contents
    for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0);

    // Aligned write/read, same-cycle AW+W
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h10, 0, 1);
    // W leads AW by 3 cycles, single byte lane
    do_write(32'h10, 32'h0000_00AA, 4'b0001, 3, 0, 0);
    do_read(32'h10, 0, 1);
    check("model_byte_merge", model[4], 32'hDEAD_BEAA);
    // AW leads W
    do_write(32'h18, 32'h1234_5678, 4'b0110, 0, 2, 1);
    do_read(32'h18, 1, 1);
    // Out of range: no RAM change, SLVERR, no aliasing onto low words
    do_write(32'h1000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_write(32'h2000_0010, 32'h0BAD_0BAD, 4'hF, 0, 0, 0);
    do_read(32'h1000, 0, 1);
    do_read(32'h0, 0, 1);
    do_read(32'h10, 0, 1);
    // Zero strobe
    do_write(32'h1C, 32'hCAFE_F00D, 4'h0, 0, 0, 0);
    do_read(32'h1C, 0, 1);
    // Backpressure on both response channels
    do_write(32'h20, 32'hA5A5_5A5A, 4'hF, 0, 0, 5);
    do_read(32'h20, 4, 1);
    // Same-edge commit and sample on word 5: read sees the old data
    fork
      do_read(32'h14, 0, 1);
      begin
        repeat (2) begin @(posedge clk); #1; end
        do_write(32'h14, 32'h7777_1111, 4'hF, 0, 0, 0);
      end
    join
    do_read(32'h14, 0, 1);
    // Misaligned accesses (SLVERR only with the alignment check built in)
    do_write(32'h13, 32'h0000_0055, 4'hF, 0, 0, 0);
    do_read(32'h10, 0, 1);
    do_read(32'h11, 0, 1);

    // Reset while R is pending
    do_read(32'h10, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_r.delete();
    exp_b.delete();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_readies_up("after_mid_reset");
    do_read(32'h10, 0, 1);

    // Randomised serial traffic
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = oor[$urandom_range(0, 3)];
      else begin
        a = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3), 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("b_left_outstanding", 32'(exp_b.size()), 32'd0);
    check("r_left_outstanding", 32'(exp_r.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
